// File: rtl/ref_clk_failover_ctrl.sv
// Reference clock failover: qualifies two async tick streams per window and
// selects the active reference with a guarded switchover. Optional macro REVERT_EN.
module ref_clk_failover_ctrl #(
  parameter int WIN_LEN = 128,
  parameter int CNT_MIN = 6,
  parameter int CNT_MAX = 40,
  parameter int GOOD_N  = 4,
  parameter int BAD_N   = 2,
  parameter int GUARD   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       f5_div,
  input  logic       f64_div,
  output logic       sel,
  output logic       out_en,
  output logic       locked,
  output logic       ERROR_5,
  output logic       ERROR_64,
  output logic       sw_pulse,
  output logic [7:0] cnt_5,
  output logic [7:0] cnt_64,
  output logic [2:0] dbg_state
);

  localparam int WIN_W = $clog2(WIN_LEN);
  localparam int G_W   = $clog2(GUARD);
  localparam int MAXN  = (GOOD_N > BAD_N) ? GOOD_N : BAD_N;
  localparam int RUN_W = $clog2(MAXN + 1);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
  localparam logic [G_W-1:0]   G_MID_M1 = G_W'(GUARD / 2 - 1);
  localparam logic [G_W-1:0]   G_LAST   = G_W'(GUARD - 1);
  localparam logic [7:0]       MIN_V    = 8'(CNT_MIN);
  localparam logic [7:0]       MAX_V    = 8'(CNT_MAX);
  localparam logic [RUN_W-1:0] GOOD_V   = RUN_W'(GOOD_N);
  localparam logic [RUN_W-1:0] BAD_V    = RUN_W'(BAD_N);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_RUN_A = 3'd1,
    S_RUN_B = 3'd2,
    S_SW    = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  // Index 0 is the primary (f5_div, "A"), index 1 the secondary (f64_div, "B").
  logic [1:0]            din;
  logic [1:0][2:0]       sync_q;
  logic [1:0]            edge_det;
  logic [WIN_W-1:0]      win_q;
  logic                  win_end;
  logic [1:0][7:0]       ec_q;
  logic [1:0][7:0]       cnt_q;
  logic [1:0][RUN_W-1:0] good_q, good_d;
  logic [1:0][RUN_W-1:0] bad_q, bad_d;
  logic [1:0]            ok_q, ok_d;
  logic [1:0]            win_good;

  state_t         state_q, state_d;
  logic           tgt_q, tgt_d;
  logic [G_W-1:0] g_q, g_d;
  logic           sel_q, sel_d;
  logic           sw_pulse_q;

  assign din     = {f64_div, f5_div};
  assign win_end = (win_q == WIN_LAST);

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      // bit0 = s0, bit1 = s1, bit2 = s2
      edge_det[i] = sync_q[i][1] & ~sync_q[i][2];
      win_good[i] = (ec_q[i] >= MIN_V) && (ec_q[i] <= MAX_V) && (ec_q[i] != 8'hFF);
      if (win_good[i]) begin
        good_d[i] = (good_q[i] == GOOD_V) ? good_q[i] : good_q[i] + 1'b1;
        bad_d[i]  = '0;
      end else begin
        good_d[i] = '0;
        bad_d[i]  = (bad_q[i] == BAD_V) ? bad_q[i] : bad_q[i] + 1'b1;
      end
      if (good_d[i] == GOOD_V) begin
        ok_d[i] = 1'b1;
      end else if (bad_d[i] == BAD_V) begin
        ok_d[i] = 1'b0;
      end else begin
        ok_d[i] = ok_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      win_q  <= '0;
      ec_q   <= '0;
      cnt_q  <= '0;
      good_q <= '0;
      bad_q  <= '0;
      ok_q   <= '0;
    end else begin
      win_q <= win_end ? '0 : win_q + 1'b1;
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][1:0], din[i]};
        if (win_end) begin
          // An edge on the boundary cycle opens the next window.
          cnt_q[i]  <= ec_q[i];
          ec_q[i]   <= {7'd0, edge_det[i]};
          good_q[i] <= good_d[i];
          bad_q[i]  <= bad_d[i];
          ok_q[i]   <= ok_d[i];
        end else if (edge_det[i] && (ec_q[i] != 8'hFF)) begin
          ec_q[i] <= ec_q[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    g_d     = '0;
    sel_d   = sel_q;
    case (state_q)
      S_INIT: begin
        if (ok_q[0]) begin
          state_d = S_RUN_A;
        end else if (ok_q[1]) begin
          state_d = S_SW;
          tgt_d   = 1'b1;
        end
      end
      S_RUN_A: begin
        if (!ok_q[0]) begin
          if (ok_q[1]) begin
            state_d = S_SW;
            tgt_d   = 1'b1;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_RUN_B: begin
        if (!ok_q[1]) begin
          if (ok_q[0]) begin
            state_d = S_SW;
            tgt_d   = 1'b0;
          end else begin
            state_d = S_HOLD;
          end
        end
`ifdef REVERT_EN
        else if (ok_q[0]) begin
          state_d = S_SW;
          tgt_d   = 1'b0;
        end
`endif
      end
      S_SW: begin
        // The guard always runs to completion regardless of health changes.
        g_d = g_q + 1'b1;
        if (g_q == G_MID_M1) begin
          sel_d = tgt_q;
        end
        if (g_q == G_LAST) begin
          g_d = '0;
          if (ok_q[tgt_q]) begin
            state_d = tgt_q ? S_RUN_B : S_RUN_A;
          end else if (ok_q[~tgt_q]) begin
            tgt_d = ~tgt_q;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (ok_q[sel_q]) begin
          state_d = sel_q ? S_RUN_B : S_RUN_A;
        end else if (ok_q[0]) begin
          state_d = S_SW;
          tgt_d   = 1'b0;
        end else if (ok_q[1]) begin
          state_d = S_SW;
          tgt_d   = 1'b1;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_INIT;
      tgt_q      <= 1'b0;
      g_q        <= '0;
      sel_q      <= 1'b0;
      sw_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      g_q        <= g_d;
      sel_q      <= sel_d;
      sw_pulse_q <= (sel_d != sel_q);
    end
  end

  assign sel       = sel_q;
  assign out_en    = (state_q == S_RUN_A) || (state_q == S_RUN_B);
  assign locked    = out_en;
  assign ERROR_5   = ~ok_q[0];
  assign ERROR_64  = ~ok_q[1];
  assign sw_pulse  = sw_pulse_q;
  assign cnt_5     = cnt_q[0];
  assign cnt_64    = cnt_q[1];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ref_clk_failover_ctrl.sv
// Bench for ref_clk_failover_ctrl: window/verdict-history reference model,
// directed scenarios then randomized tick patterns on both inputs.
module tb_ref_clk_failover_ctrl;
  localparam int WIN_LEN = 128;
  localparam int CNT_MIN = 6;
  localparam int CNT_MAX = 40;
  localparam int GOOD_N  = 4;
  localparam int BAD_N   = 2;
  localparam int GUARD   = 16;

  localparam int M_START  = 0;
  localparam int M_ON     = 1;
  localparam int M_SWITCH = 2;
  localparam int M_WAIT   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       f5_div = 1'b0;
  logic       f64_div = 1'b0;
  logic       sel, out_en, locked, ERROR_5, ERROR_64, sw_pulse;
  logic [7:0] cnt_5, cnt_64;
  logic [2:0] dbg_state;

  ref_clk_failover_ctrl #(
    .WIN_LEN(WIN_LEN), .CNT_MIN(CNT_MIN), .CNT_MAX(CNT_MAX),
    .GOOD_N(GOOD_N), .BAD_N(BAD_N), .GUARD(GUARD)
  ) dut (
    .clk(clk), .rst(rst), .f5_div(f5_div), .f64_div(f64_div),
    .sel(sel), .out_en(out_en), .locked(locked),
    .ERROR_5(ERROR_5), .ERROR_64(ERROR_64), .sw_pulse(sw_pulse),
    .cnt_5(cnt_5), .cnt_64(cnt_64), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: expected {sel,out_en,locked,ERROR_5,ERROR_64,sw_pulse,cnt_5,cnt_64}
  logic [21:0] exp_q[$];

  // reference model state
  int m_c;
  int m_acc[2];
  int m_cnt[2];
  int m_hist[2];   // window verdicts, bit0 = most recent
  int m_ihist[2];  // sampled input values, bit0 = most recent
  bit m_ok[2];
  int m_mode;
  bit m_sel, m_tgt, m_pulse;
  int m_t;

  // stimulus generators: period 0 = idle low, 1 = stuck high
  int per_p[2];
  int ph[2];
  int pulse_cnt;

  function automatic logic [21:0] pack_exp();
    bit on;
    on = (m_mode == M_ON);
    return {m_sel, on, on, ~m_ok[0], ~m_ok[1], m_pulse, 8'(m_cnt[0]), 8'(m_cnt[1])};
  endfunction

  function automatic void begin_switch(bit to);
    m_mode = M_SWITCH;
    m_tgt  = to;
    m_t    = 0;
  endfunction

  task automatic model_reset();
    m_c = 0;
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 0; m_cnt[i] = 0; m_hist[i] = 0; m_ihist[i] = 0; m_ok[i] = 1'b0;
    end
    m_mode = M_START; m_sel = 1'b0; m_tgt = 1'b0; m_pulse = 1'b0; m_t = 0;
    exp_q.delete();
    exp_q.push_back(pack_exp());
  endtask

  // Advance the model across one rising clock edge with inputs a (f5) and b (f64).
  task automatic model_advance(input bit a, input bit b);
    bit ok_now[2];
    bit seen[2];
    bit good;
    int gmask, bmask;
    gmask = (1 << GOOD_N) - 1;
    bmask = (1 << BAD_N) - 1;
    for (int i = 0; i < 2; i++) begin
      ok_now[i] = m_ok[i];
      seen[i] = (((m_ihist[i] >> 1) & 1) == 1) && (((m_ihist[i] >> 2) & 1) == 0);
    end
    m_pulse = 1'b0;
    case (m_mode)
      M_START: begin
        if (ok_now[0]) m_mode = M_ON;
        else if (ok_now[1]) begin_switch(1'b1);
      end
      M_ON: begin
        if (!ok_now[m_sel]) begin
          if (ok_now[!m_sel]) begin_switch(!m_sel);
          else m_mode = M_WAIT;
        end
`ifdef REVERT_EN
        else if (m_sel && ok_now[0]) begin_switch(1'b0);
`endif
      end
      M_SWITCH: begin
        m_t++;
        if (m_t == GUARD / 2 && m_sel != m_tgt) begin
          m_sel = m_tgt;
          m_pulse = 1'b1;
        end
        if (m_t == GUARD) begin
          if (ok_now[m_tgt]) m_mode = M_ON;
          else if (ok_now[!m_tgt]) begin_switch(!m_tgt);
          else m_mode = M_WAIT;
        end
      end
      default: begin
        if (ok_now[m_sel]) m_mode = M_ON;
        else if (ok_now[0]) begin_switch(1'b0);
        else if (ok_now[1]) begin_switch(1'b1);
      end
    endcase
    for (int i = 0; i < 2; i++) begin
      if ((m_c % WIN_LEN) == WIN_LEN - 1) begin
        m_cnt[i] = m_acc[i];
        good = (m_acc[i] >= CNT_MIN) && (m_acc[i] <= CNT_MAX) && (m_acc[i] != 255);
        m_hist[i] = ((m_hist[i] << 1) | int'(good)) & 255;
        if ((m_hist[i] & gmask) == gmask) m_ok[i] = 1'b1;
        else if ((m_hist[i] & bmask) == 0) m_ok[i] = 1'b0;
        m_acc[i] = seen[i] ? 1 : 0;
      end else if (seen[i] && m_acc[i] < 255) begin
        m_acc[i]++;
      end
    end
    m_ihist[0] = ((m_ihist[0] << 1) | int'(a)) & 7;
    m_ihist[1] = ((m_ihist[1] << 1) | int'(b)) & 7;
    m_c++;
    exp_q.push_back(pack_exp());
  endtask

  function automatic bit gen(int i);
    bit v;
    if (per_p[i] == 0) return 1'b0;
    if (per_p[i] == 1) return 1'b1;
    v = (ph[i] < per_p[i] / 2);
    ph[i] = (ph[i] + 1) % per_p[i];
    return v;
  endfunction

  // driver: called at a falling edge, returns at the next falling edge
  task automatic tick();
    logic [21:0] e;
    bit a, b;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("outs", {10'd0, sel, out_en, locked, ERROR_5, ERROR_64, sw_pulse, cnt_5, cnt_64},
               {10'd0, e});
    end
    if (sw_pulse) pulse_cnt++;
    a = gen(0);
    b = gen(1);
    f5_div  = a;
    f64_div = b;
    model_advance(a, b);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_sel"}, 32'(sel), 32'd0);
    check_eq({tag, "_out_en"}, 32'(out_en), 32'd0);
    check_eq({tag, "_locked"}, 32'(locked), 32'd0);
    check_eq({tag, "_err5"}, 32'(ERROR_5), 32'd1);
    check_eq({tag, "_err64"}, 32'(ERROR_64), 32'd1);
    check_eq({tag, "_pulse"}, 32'(sw_pulse), 32'd0);
    check_eq({tag, "_cnt5"}, 32'(cnt_5), 32'd0);
    check_eq({tag, "_cnt64"}, 32'(cnt_64), 32'd0);
  endtask

  task automatic align_window();
    while ((m_c % WIN_LEN) != 5) tick();
  endtask

  initial begin
    int found;
    per_p[0] = 0; per_p[1] = 0; ph[0] = 0; ph[1] = 0; pulse_cnt = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst = 1'b0;
    model_reset();

    // primary alone qualifies and is selected
    per_p[0] = 16;
    run(4 * WIN_LEN + 10);
    check_eq("a_sel", 32'(sel), 32'd0);
    check_eq("a_out_en", 32'(out_en), 32'd1);
    check_eq("a_locked", 32'(locked), 32'd1);
    check_eq("a_err5", 32'(ERROR_5), 32'd0);
    check_eq("a_err64", 32'(ERROR_64), 32'd1);

    // secondary qualifies, then primary dies: switch to B
    per_p[1] = 16; ph[1] = ph[0];
    run(6 * WIN_LEN);
    check_eq("b_err64", 32'(ERROR_64), 32'd0);
    align_window();
    pulse_cnt = 0;
    per_p[0] = 0;
    run(3 * WIN_LEN + 40);
    check_eq("b_sel", 32'(sel), 32'd1);
    check_eq("b_out_en", 32'(out_en), 32'd1);
    check_eq("b_cnt5", 32'(cnt_5), 32'd0);
    check_eq("b_err5", 32'(ERROR_5), 32'd1);
    check_eq("b_pulses", 32'(pulse_cnt), 32'd1);

    // back to A, then both die together: HOLD
    per_p[0] = 16; ph[0] = ph[1];
    run(8 * WIN_LEN);
    align_window();
    pulse_cnt = 0;
    per_p[0] = 0; per_p[1] = 0;
    run(3 * WIN_LEN + 40);
    check_eq("c_out_en", 32'(out_en), 32'd0);
    check_eq("c_locked", 32'(locked), 32'd0);
    check_eq("c_sel", 32'(sel), 32'(m_sel));
    check_eq("c_pulses", 32'(pulse_cnt), 32'd0);

    // primary too fast, secondary back
    per_p[0] = 2; ph[0] = 0;
    per_p[1] = 16; ph[1] = 0;
    run(6 * WIN_LEN + 40);
    check_eq("d_cnt5", 32'(cnt_5), 32'd64);
    check_eq("d_err5", 32'(ERROR_5), 32'd1);
    check_eq("d_sel", 32'(sel), 32'd1);
    check_eq("d_out_en", 32'(out_en), 32'd1);

    // primary restored while on B
    per_p[0] = 16; ph[0] = 0;
    run(7 * WIN_LEN);
`ifdef REVERT_EN
    check_eq("e_sel", 32'(sel), 32'd0);
`else
    check_eq("e_sel", 32'(sel), 32'd1);
`endif
    check_eq("e_out_en", 32'(out_en), 32'd1);

    // kill the selected source and reset in the middle of the guard
    per_p[m_sel] = 0;
    found = 0;
    for (int k = 0; k < 3000 && found == 0; k++) begin
      tick();
      if (m_mode == M_SWITCH && m_t == 5) found = 1;
    end
    check_eq("reach_sw", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_values("midsw");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run(2 * WIN_LEN);

    // randomized segments
    for (int s = 0; s < 30; s++) begin
      for (int i = 0; i < 2; i++) begin
        case ($urandom_range(0, 9))
          0, 1: per_p[i] = 0;
          2: per_p[i] = 2;
          3: per_p[i] = 1;
          default: per_p[i] = $urandom_range(3, 26);
        endcase
        ph[i] = (per_p[i] > 1) ? $urandom_range(0, per_p[i] - 1) : 0;
      end
      run($urandom_range(600, 1400));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ref_clk_failover_ctrl.md
Name: ref_clk_failover_ctrl

Overview:
- Monitors two divided-down reference tick streams (f5_div, f64_div), both asynchronous to clk.
- Counts rising edges per fixed measurement window and applies hysteresis to qualify each source as healthy or failed.
- Selects the active reference through a guarded switchover state machine.
- Sits between the reference input dividers and the timing generator; drives the reference mux select and mux output enable.

Parameters:
- WIN_LEN, 128: measurement window length in clk cycles.
- CNT_MIN, 6: minimum edges per window for a good window.
- CNT_MAX, 40: maximum edges per window for a good window.
- GOOD_N, 4: consecutive good windows to declare a source OK.
- BAD_N, 2: consecutive bad windows to declare a source failed.
- GUARD, 16: switchover guard length in clk cycles; even, ≥4.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- f5_div  in  1  primary reference ticks, async.
- f64_div  in  1  secondary reference ticks, async.
- sel  out  1  active source: 0 = f5_div, 1 = f64_div.
- out_en  out  1  reference mux output enable.
- locked  out  1  a healthy source is selected and passed through.
- ERROR_5  out  1  primary not OK.
- ERROR_64  out  1  secondary not OK.
- sw_pulse  out  1  one-cycle strobe on every change of sel.
- cnt_5  out  8  primary edge count of last completed window.
- cnt_64  out  8  secondary edge count of last completed window.

Behaviour:
- Reset values (async, active-high, applied immediately): sel=0, out_en=0, locked=0, ERROR_5=1, ERROR_64=1, sw_pulse=0, cnt_5=0, cnt_64=0. Clock one clk domain only. Asserting rst mid-operation aborts any window, run counters, or switchover.
- Sync: each input passes a 3-flop synchroniser (s0→s1→s2). Edge detect = s1 & ~s2, one clk per rising edge. Edge-to-count latency is 3 clk.
- Window: win_cnt runs 0..WIN_LEN-1 and wraps. Edge counters are 8 bits and saturate at 255.
- Window end (win_cnt==WIN_LEN-1):
  - Counts copy to cnt_5/cnt_64.
  - Edge counters load 1 if an edge is present that cycle, else 0; that edge belongs to the new window.
- Good window: CNT_MIN ≤ count ≤ CNT_MAX. A saturated count (255) is bad.
- Health, per source, updated at window end:
  - good_run/bad_run count consecutive good/bad windows and saturate.
  - A good window clears bad_run; a bad window clears good_run.
  - ok sets when good_run reaches GOOD_N and clears when bad_run reaches BAD_N. ok holds otherwise.
  - ERROR_x = ~ok_x, registered in the same cycle.
- FSM reacts one clk after a health update.
- States:
  - INIT: out_en=0, locked=0. ok_5 → RUN_A. Else ok_64 → SW with target B.
  - RUN_A: sel=0, out_en=1, locked=1. On !ok_5: ok_64 → SW target B, else HOLD.
  - RUN_B: sel=1, out_en=1, locked=1. On !ok_64: ok_5 → SW target A, else HOLD.
  - SW (guard counter g = 0..GUARD-1):
    - out_en=0 and locked=0 from the entry cycle.
    - sel takes the target value at g==GUARD/2, with sw_pulse=1 in that cycle.
    - At g==GUARD-1: target ok → RUN_target. Else other source ok → SW back to the other source, with g restarting. Else HOLD.
    - Health changes during SW never shorten the guard.
  - HOLD: out_en=0, locked=0, sel held.
    - A source that is ok and equal to the current sel → RUN of that source, with no guard.
    - Else an ok source → SW. If both are ok, prefer A.
- Simultaneous loss of both sources in RUN → HOLD.
- Simultaneous recovery of both sources in INIT/HOLD → prefer A.
- sw_pulse is never asserted outside SW.

Optional Feature:
- Macro: REVERT_EN.
- Defined: in RUN_B, ok_5 true → SW target A (revertive), so the primary is reclaimed after GOOD_N good windows.
- Undefined: RUN_B stays until ok_64 clears (non-revertive). All other behaviour is identical.

Test Plan:
- Reset, f5_div period 16 clk (8 edges/window), f64_div idle → ERROR_5 falls after 4 windows (~512+4 clk), RUN_A, sel=0, out_en=1, locked=1, ERROR_64=1.
- From RUN_A with both inputs at period 16, stop f5_div → after 2 bad windows ERROR_5=1; out_en drops next clk; sel=1 with sw_pulse 8 clk later; out_en=1 16 clk after entry; cnt_5=0.
- Both inputs stopped while in RUN_A → HOLD, out_en=0, locked=0, sel stays 0, sw_pulse never asserted.
- f5_div period 2 (64 edges > CNT_MAX) → treated as bad; cnt_5=64; ERROR_5 stays 1.
- Restore f5_div while in RUN_B → with REVERT_EN: after 4 good windows, SW back to sel=0. Without REVERT_EN: sel stays 1 indefinitely.
- Assert rst mid-SW (g=5) → all outputs at reset values in the same cycle; after release the FSM restarts from INIT.
